scan_chain_ctrl: RTL and testbench
==================================

# scan_chain_ctrl

Scan-chain controller that drives the serial scan port of the parameterised shift register stage. On a start request it optionally pulses the register's parallel-load enable to capture its data input, then shifts a supplied word serially into the register MSB-first. At the same time it collects the bits falling out of `scan_out` into a parallel capture word. It sits directly upstream of the shift register's `enable`/`scan_enable`/`scan_in` inputs and downstream of its `scan_out`.

## Interface
- `WIDTH`, default 8: chain length in bits; must equal the attached register's WIDTH, and must be ≥ 2.
- `clk` input, 1: single clock; all state updates on its rising edge.
- `rst` input, 1: reset, asynchronous and active-high.
- `start` input, 1: operation request; sampled only in IDLE.
- `capture_first` input, 1: sampled with `start`; 1 = run CAPTURE before SHIFT.
- `load_word` input, WIDTH: word to shift into the chain; sampled with `start`.
- `busy` output, 1: high from the cycle after an accepted `start` through the DONE cycle inclusive.
- `done` output, 1: one-cycle pulse; marks `capture_word` valid.
- `capture_word` output, WIDTH: bits shifted out of the chain; holds its value until the next DONE.
- `reg_enable` output, 1: drives the register's `enable`.
- `scan_enable` output, 1: drives the register's `scan_enable`.
- `scan_in` output, 1: drives the register's `scan_in`.
- `scan_out` input, 1: from the register's `scan_out`, which is the register MSB.

## Operation
- States: IDLE, CAPTURE, SHIFT, DONE.
- IDLE:
  - If `start`=1, latch `load_word` into shift buffer `sbuf`, clear bit counter `cnt` (width $clog2(WIDTH)).
  - Then go to CAPTURE if `capture_first`=1, else SHIFT.
- CAPTURE: lasts one cycle with `reg_enable`=1, then go to SHIFT.
- SHIFT:
  - Lasts exactly WIDTH cycles, with `scan_enable`=1 in every one.
  - `scan_in` = `sbuf[WIDTH-1]`.
  - At each edge: `sbuf` <= `sbuf` << 1 and `cbuf` <= {`cbuf[WIDTH-2:0]`, `scan_out`}; `cnt` increments.
  - When `cnt`=WIDTH-1, that edge moves to DONE.
- DONE: `capture_word` <= `cbuf`, `done`=1 for one cycle, then return to IDLE.
- Result: after SHIFT the register holds `load_word`. `capture_word` equals the register contents just before SHIFT began; with `capture_first`=1 that is the register's `data_in` as sampled in the CAPTURE cycle.
- `reg_enable` and `scan_enable` are never high in the same cycle. Both are low in IDLE and DONE.
- `start` is ignored in every state other than IDLE; there is no queuing.
- `start` may be asserted in the cycle right after DONE (back-to-back operation).
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.

## Timing
- Reset values: state=IDLE; `busy`, `done`, `reg_enable`, `scan_enable`, `scan_in` all 0; `sbuf`, `cbuf`, `capture_word`, `cnt` all 0.
- `rst` asserted mid-operation aborts immediately and asynchronously to the reset values. No `done` is produced and `capture_word` is cleared.
- `start` sampled at edge T, with `capture_first`=0:
  - `scan_enable` high in cycles T+1..T+WIDTH.
  - `done` high in cycle T+WIDTH+1.
  - `busy` high in cycles T+1..T+WIDTH+1.
- With `capture_first`=1:
  - `reg_enable` high in cycle T+1.
  - SHIFT in cycles T+2..T+WIDTH+1.
  - `done` high in cycle T+WIDTH+2.
- `capture_word` updates at the edge ending the DONE cycle. It is therefore valid from the cycle after `done`; the bench samples it one cycle after `done`.
- `scan_out` is sampled at the edge that completes each shift cycle, i.e. before the register shifts.

## Test plan
- Reset: hold `rst` while toggling `start` -> all outputs 0, `busy` never rises.
- WIDTH=8, register preloaded 0xA5, `start` with `load_word`=0x3C, `capture_first`=0:
  - `scan_in` sequence 0,0,1,1,1,1,0,0 across 8 `scan_enable` cycles.
  - Register = 0x3C afterwards; `capture_word`=0xA5.
  - `done` pulses at T+9.
- Register `data_in`=0x81, `capture_first`=1, `load_word`=0xFF:
  - `reg_enable` high exactly one cycle, then 8 shift cycles.
  - `capture_word`=0x81, register=0xFF, `done` at T+10.
- `start` pulsed during SHIFT -> ignored; exactly one `done`; `capture_word` unchanged by the extra pulse.
- `rst` asserted in SHIFT cycle 4 -> outputs 0 immediately; no `done`; a new `start` afterwards completes normally with correct data.
- Back-to-back: `start` held high continuously -> operations repeat every WIDTH+2 cycles. Check `reg_enable` and `scan_enable` are never high together.

Source files
------------

// File: rtl/scan_chain_ctrl_if.sv
// rtl/scan_chain_ctrl_if.sv - request/result and serial scan port bundle for scan_chain_ctrl
interface scan_chain_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             capture_first;
    logic [WIDTH-1:0] load_word;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] capture_word;
    logic             reg_enable;
    logic             scan_enable;
    logic             scan_in;
    logic             scan_out;

    modport master (
        output start, capture_first, load_word, scan_out,
        input  busy, done, capture_word, reg_enable, scan_enable, scan_in
    );

    modport slave (
        input  start, capture_first, load_word, scan_out,
        output busy, done, capture_word, reg_enable, scan_enable, scan_in
    );
endinterface

// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - scan-chain controller: optional capture, MSB-first shift-in, parallel capture-out
module scan_chain_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    scan_chain_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_SHIFT   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sbuf;
    logic [WIDTH-1:0] r_cbuf;
    logic [WIDTH-1:0] r_capture_word;
    logic [CW-1:0]    r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = bus.capture_first ? S_CAPTURE : S_SHIFT;
                end
            end
            S_CAPTURE: w_next = S_SHIFT;
            S_SHIFT: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // scan_out is the register MSB before this edge's shift, so it lands in cbuf LSB-first-in order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sbuf         <= '0;
            r_cbuf         <= '0;
            r_capture_word <= '0;
            r_cnt          <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sbuf <= bus.load_word;
                        r_cnt  <= '0;
                    end
                end
                S_SHIFT: begin
                    r_sbuf <= {r_sbuf[WIDTH-2:0], 1'b0};
                    r_cbuf <= {r_cbuf[WIDTH-2:0], bus.scan_out};
                    r_cnt  <= r_cnt + 1'b1;
                end
                S_DONE: begin
                    r_capture_word <= r_cbuf;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.reg_enable  = 1'b0;
        bus.scan_enable = 1'b0;
        bus.scan_in     = 1'b0;
        case (r_state)
            S_CAPTURE: begin
                bus.busy       = 1'b1;
                bus.reg_enable = 1'b1;
            end
            S_SHIFT: begin
                bus.busy        = 1'b1;
                bus.scan_enable = 1'b1;
                bus.scan_in     = r_sbuf[WIDTH-1];
            end
            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.capture_word = r_capture_word;
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb/tb_scan_chain_ctrl.sv - self-checking bench for scan_chain_ctrl with an attached shift-register model
module tb_scan_chain_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] plant;
    logic         pl_en = 1'b0;
    logic [W-1:0] pl_val = '0;
    int           total = 0;
    int           passed = 0;

    scan_chain_ctrl_if #(.WIDTH(W)) bus ();

    scan_chain_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // attached register: parallel load on enable, shift toward MSB on scan_enable
    always @(posedge clk) begin
        if (pl_en) plant <= pl_val;
        else if (bus.reg_enable) plant <= data_in;
        else if (bus.scan_enable) plant <= {plant[W-2:0], bus.scan_in};
    end
    assign bus.scan_out = plant[W-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic preload(input logic [W-1:0] v);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_val = v;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    task automatic run_op(input logic cf, input logic [W-1:0] lw, input logic [W-1:0] din, input int glitch_at);
        logic [W-1:0] exp_cap;
        logic [W-1:0] sin_word;
        logic [W-1:0] cap_obs;
        int n_sh, n_re, first_se, done_k, n_done, busy_bad, overlap;
        sin_word = '0; cap_obs = 'x;
        n_sh = 0; n_re = 0; first_se = 0; done_k = 0; n_done = 0; busy_bad = 0; overlap = 0;
        @(negedge clk);
        data_in           = din;
        exp_cap           = cf ? din : plant;
        bus.start         = 1'b1;
        bus.capture_first = cf;
        bus.load_word     = lw;
        @(posedge clk);
        #1;
        bus.start         = 1'b0;
        bus.load_word     = ~lw;
        bus.capture_first = ~cf;
        for (int k = 1; k <= 3 * W; k++) begin
            @(negedge clk);
            bus.start = (k == glitch_at);
            if (done_k == 0 && !bus.busy) busy_bad++;
            if (done_k != 0 && k == done_k + 1) begin
                if (bus.busy) busy_bad++;
                cap_obs = bus.capture_word;
            end
            if (bus.scan_enable) begin
                sin_word = {sin_word[W-2:0], bus.scan_in};
                n_sh++;
                if (first_se == 0) first_se = k;
            end
            if (bus.reg_enable) n_re++;
            if (bus.reg_enable && bus.scan_enable) overlap++;
            if (bus.done) begin
                n_done++;
                if (done_k == 0) done_k = k;
            end
        end
        bus.start = 1'b0;
        check("scan_in_seq", 32'(sin_word), 32'(lw));
        check("shift_cycles", n_sh, W);
        check("reg_enable_cycles", n_re, 32'(cf));
        check("first_shift_cycle", first_se, 1 + 32'(cf));
        check("done_cycle", done_k, W + 1 + 32'(cf));
        check("done_count", n_done, 1);
        check("busy_window", busy_bad, 0);
        check("enable_overlap", overlap, 0);
        check("capture_word", 32'(cap_obs), 32'(exp_cap));
        check("register_after", 32'(plant), 32'(lw));
    endtask

    initial begin
        int busy_seen;
        int done_seen;
        int q[$];
        int ov;
        bus.start = 1'b0;
        bus.capture_first = 1'b0;
        bus.load_word = '0;
        plant = '0;

        busy_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.start = ~bus.start;
            bus.load_word = W'($urandom);
            #1;
            if (bus.busy) busy_seen++;
        end
        check("reset_busy_never", busy_seen, 0);
        check("reset_outputs", {bus.busy, bus.done, bus.reg_enable, bus.scan_enable, bus.scan_in, bus.capture_word}, 0);
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b0;

        preload(8'hA5);
        run_op(1'b0, 8'h3C, 8'h00, 0);
        preload(8'h42);
        run_op(1'b1, 8'hFF, 8'h81, 0);
        run_op(1'b0, 8'h5A, 8'h00, 4);

        @(negedge clk);
        bus.start = 1'b1;
        bus.capture_first = 1'b0;
        bus.load_word = 8'hC3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_outputs", {bus.busy, bus.done, bus.reg_enable, bus.scan_enable, bus.scan_in, bus.capture_word}, 0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        rst = 1'b0;
        run_op(1'b0, 8'hE7, 8'h00, 0);

        @(negedge clk);
        bus.start = 1'b1;
        bus.capture_first = 1'b0;
        bus.load_word = 8'h96;
        ov = 0;
        for (int k = 1; k <= 5 * (W + 2); k++) begin
            @(negedge clk);
            if (bus.done) q.push_back(k);
            if (bus.reg_enable && bus.scan_enable) ov++;
        end
        bus.start = 1'b0;
        repeat (2 * W) @(negedge clk);
        check("b2b_done_count", q.size(), 5);
        for (int i = 0; i + 1 < q.size(); i++) check("b2b_period", q[i+1] - q[i], W + 2);
        check("b2b_overlap", ov, 0);
        check("b2b_register", 32'(plant), 32'h96);

        for (int n = 0; n < 16; n++) begin
            int g;
            g = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, W)) : 0;
            preload(W'($urandom));
            run_op(1'($urandom), W'($urandom), W'($urandom), g);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
